// File: rtl/control_d_writeback.sv
// Result drain: takes lane-skewed PE results and drives the per-lane SRAM write ports, packing FP16 pairs.
// Optional lane skew checker is compiled in with `define CONTROL_D_ERRCHK_EN.

package params;
   typedef enum logic [1:0] {DT_INT8 = 2'd0, DT_INT4 = 2'd1, DT_FP16 = 2'd2, DT_INT32 = 2'd3} datatype_t;
   typedef struct packed {
      datatype_t datatype;
   } addrgen_t;
endpackage

module control_d_writeback_lane #(
   parameter int AW = 6,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vld,
   input  logic          fp16,
   input  logic          ph,
   input  logic          last,
   input  logic [AW-1:0] base,
   input  logic [AW-1:0] wcnt,
   input  logic [DW-1:0] res,
   output logic          we,
   output logic [AW-1:0] wraddr,
   output logic [DW-1:0] wdata
);
   logic          we_q, we_d;
   logic [AW-1:0] wraddr_q, wraddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [15:0]   held_q, held_d;

   always_comb begin
      we_d     = 1'b0;
      wraddr_d = wraddr_q;
      wdata_d  = wdata_q;
      held_d   = held_q;
      if (vld) begin
         if (fp16 && !ph && !last) begin
            held_d = res[15:0];
         end else begin
            we_d     = 1'b1;
            wraddr_d = base + wcnt;
            if (!fp16)  wdata_d = res;
            else if (ph) wdata_d = DW'({res[15:0], held_q});
            else         wdata_d = DW'(res[15:0]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q     <= 1'b0;
         wraddr_q <= '0;
         wdata_q  <= '0;
         held_q   <= '0;
      end else begin
         we_q     <= we_d;
         wraddr_q <= wraddr_d;
         wdata_q  <= wdata_d;
         held_q   <= held_d;
      end
   end

   assign we     = we_q;
   assign wraddr = wraddr_q;
   assign wdata  = wdata_q;
endmodule

module control_d_writeback #(
   parameter int LANES = 8,
   parameter int AW    = 6,
   parameter int DW    = 32,
   parameter int CW    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [AW-1:0]              base_addr,
   input  logic [CW-1:0]              nres,
   input  params::addrgen_t           addrtype,
   input  logic [LANES-1:0]           res_valid,
   input  logic [LANES-1:0][DW-1:0]   res_data,
   output logic [LANES-1:0]           we,
   output logic [LANES-1:0][AW-1:0]   wraddr,
   output logic [LANES-1:0][DW-1:0]   wdata,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);
   localparam int FW = $clog2(LANES);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
   typedef struct packed {
      logic [AW-1:0] wcnt;
      logic          ph;
      logic          last;
   } tup_t;

   state_t        state_q, state_d;
   logic [AW-1:0] base_q, base_d, wcnt_q, wcnt_d;
   logic [CW-1:0] nres_q, nres_d, acnt_q, acnt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          fp16_q, fp16_d, ph_q, ph_d, zdone_q, zdone_d;
   logic          active, acc0, last0;
   tup_t          tup0;
   tup_t          chain_q [LANES-1:1];
   tup_t          chain_d [LANES-1:1];

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      nres_d  = nres_q;
      fp16_d  = fp16_q;
      acnt_d  = acnt_q;
      wcnt_d  = wcnt_q;
      ph_d    = ph_q;
      fcnt_d  = fcnt_q;
      zdone_d = 1'b0;
      active  = (state_q == S_RUN) || (state_q == S_FLUSH);
      acc0    = (state_q == S_RUN) && res_valid[0];
      last0   = (acnt_q == nres_q - CW'(1));
      case (state_q)
         S_IDLE: if (start) begin
            base_d  = base_addr;
            nres_d  = nres;
            fp16_d  = (addrtype.datatype == params::DT_FP16);
            acnt_d  = '0;
            wcnt_d  = '0;
            ph_d    = 1'b0;
            fcnt_d  = '0;
            if (nres != '0) state_d = S_RUN;
            else            zdone_d = 1'b1;
         end
         S_RUN: if (acc0) begin
            acnt_d = acnt_q + CW'(1);
            ph_d   = fp16_q & ~ph_q;
            // An FP16 word completes on the second half or on an odd tail
            if (!fp16_q || ph_q || last0) wcnt_d = wcnt_q + AW'(1);
            if (last0) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            fcnt_d = fcnt_q + FW'(1);
            if (fcnt_q == FW'(LANES-1)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      tup0 = '{wcnt: wcnt_q, ph: ph_q, last: last0};
      chain_d[1] = tup0;
      for (int i = 2; i < LANES; i++) chain_d[i] = chain_q[i-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         nres_q  <= '0;
         fp16_q  <= 1'b0;
         acnt_q  <= '0;
         wcnt_q  <= '0;
         ph_q    <= 1'b0;
         fcnt_q  <= '0;
         zdone_q <= 1'b0;
         for (int i = 1; i < LANES; i++) chain_q[i] <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         nres_q  <= nres_d;
         fp16_q  <= fp16_d;
         acnt_q  <= acnt_d;
         wcnt_q  <= wcnt_d;
         ph_q    <= ph_d;
         fcnt_q  <= fcnt_d;
         zdone_q <= zdone_d;
         for (int i = 1; i < LANES; i++) chain_q[i] <= chain_d[i];
      end
   end

   genvar g;
   for (g = 0; g < LANES; g++) begin : g_lane
      tup_t lt;
      if (g == 0) begin : g_head
         assign lt = tup0;
      end else begin : g_tail
         assign lt = chain_q[g];
      end
      control_d_writeback_lane #(.AW(AW), .DW(DW)) u_lane (
         .clk    (clk),
         .rst    (rst),
         .vld    (active & res_valid[g]),
         .fp16   (fp16_q),
         .ph     (lt.ph),
         .last   (lt.last),
         .base   (base_q),
         .wcnt   (lt.wcnt),
         .res    (res_data[g]),
         .we     (we[g]),
         .wraddr (wraddr[g]),
         .wdata  (wdata[g])
      );
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE) || zdone_q;

`ifdef CONTROL_D_ERRCHK_EN
   logic [LANES-2:0] ev_q, ev_d;
   logic [LANES-1:0] exp_v;
   logic             err_q, err_d;

   always_comb begin
      exp_v = {ev_q, acc0};
      ev_d  = exp_v[LANES-2:0];
      err_d = err_q | (active && (res_valid != exp_v));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ev_q  <= '0;
         err_q <= 1'b0;
      end else begin
         ev_q  <= ev_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule

// File: doc/control_d_writeback.md
Name: control_d_writeback

Overview:
- Result-side counterpart of the A/B operand feed units: the operand units read SRAM words and skew them into the PE array one lane per cycle. This block drains per-row results that leave the PE array with that same one-cycle-per-lane skew, and packs them per datatype.
- It generates the 8 per-lane SRAM write ports (we/wraddr/wdata).
- A small FSM sequences one drain job (start, run, flush, done).

Parameters:
- LANES, 8, number of PE lanes / SRAM banks.
- AW, 6, SRAM word address width per bank.
- DW, 32, SRAM word and result width.
- CW, 8, result-count width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job start pulse; sampled only in IDLE.
- base_addr  in  AW  first word address of the job (same for all banks).
- nres  in  CW  results per lane in this job.
- addrtype  in  params::addrgen_t  only the .datatype field is used.
- res_valid  in  LANES  per-lane result valid; lane i is nominally i cycles after lane 0.
- res_data  in  LANES x DW  per-lane result; FP16 uses [15:0].
- we  out  LANES  per-lane SRAM write enable.
- wraddr  out  LANES x AW  per-lane write address.
- wdata  out  LANES x DW  per-lane write data.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky skew error (optional feature).

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE; we, wraddr, wdata, busy, done, err all 0; chain registers and counters 0.
- datatype and base_addr are latched at start; nres is latched at start as the job count.
- The addrtype input is ignored mid-job.
- FSM states:
  - IDLE: if start and nres!=0, go to RUN. If start and nres==0, pulse done the next cycle and stay in IDLE.
  - RUN: count lane-0 accepted results (res_valid[0]); after the nres-th one, go to FLUSH.
  - FLUSH: count LANES cycles so lane 7's last write issues; then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- res_valid outside RUN/FLUSH is ignored (no write).
- Lane-0 state: word counter wcnt (AW bits), phase bit ph (FP16 only), last flag.
  - last = (accepted count == nres-1).
- Delay chain: the lane-0 tuple {expected valid, wcnt, ph, last} is registered lane to lane. Lane i sees the tuple delayed by i cycles, mirroring the operand enable/address chain.
- Lane i write rule:
  - Non-FP16: each valid result writes res_data[i] at base+wcnt.
  - FP16: results pair into one word.
    - ph=0: hold the result as the low half.
    - ph=1: write {res, held} (second result in [31:16]).
    - ph=0 with last=1: write {16'b0, res} (odd-count tail).
- Write latency: we[i], wraddr[i] and wdata[i] are registered, asserted the cycle after the accepted res_valid[i]. we is high 1 cycle per write.
- wcnt increments after each word written by lane 0 (per result for non-FP16, per pair for FP16). Address = base_addr + wcnt, modulo 2^AW (wraps 63 to 0, no flag).
- Words written per lane: nres for non-FP16; ceil(nres/2) for FP16.
- done asserts exactly one cycle after lane 7's last we.
- Simultaneous start while busy: ignored.
- Reset mid-job: all writes stop immediately (we=0 asynchronously); the held FP16 half is discarded.

Optional Feature:
- Macro CONTROL_D_ERRCHK_EN.
- With it defined: each cycle in RUN/FLUSH, if res_valid[i] differs from the lane-i delayed expected valid, err sets and stays 1 until rst. The actual res_valid still controls writes.
- Without it: err is tied to 0 and the comparison logic is absent.

Test Plan:
- INT8, base=0x10, nres=4, lane i data=0xA0000000+i*16+k at skew i -> lane i writes addrs 0x10..0x13, one per cycle starting 1 cycle after its valid; done 1 cycle after lane 7's write at 0x13; busy low the cycle after done.
- FP16, base=0x00, nres=4, lane 0 results 0x1111, 0x2222, 0x3333, 0x4444 -> lane 0 writes 0x22221111@0x00, then 0x44443333@0x01; 2 writes per lane, skewed by lane index.
- FP16, nres=3 -> second word 0x00003333@0x01 written on the third valid; no fourth write.
- INT4, base=0x3E, nres=4 -> addrs 0x3E, 0x3F, 0x00, 0x01 on every lane.
- Reset mid-job: assert rst during FLUSH -> we/busy/done drop immediately; a new job afterwards starts at its own base with no stale FP16 half.
- nres=0 start -> done pulses next cycle, no we. With CONTROL_D_ERRCHK_EN, lane 3 valid early by one cycle -> err=1 and it stays 1 until rst.
